minigame_sequencer: RTL and testbench
=====================================

// Module: minigame_sequencer
// PURPOSE
//  Parametrised top-level minigame sequencer for BitBakery, generalised to NUM_GAMES games.
//  - Runs the session FSM: idle, prepare, countdown interval, start pulse, execution, end.
//  - Latches game select and difficulty, and muxes flattened per-game buses to a single debug/score output.
//  - Adds three behaviours: invalid-select rejection, an abort path, and last-score capture.
//  - Sits between the board inputs and the minigame cores; feeds the 7-seg displays and serial TX.
// PARAMETERS
//  NUM_GAMES        4     number of minigame cores attached (1..2**SEL_W)
//  SEL_W            2     width of minigame select
//  STATE_W          4     per-game state bus width
//  JOG_W            7     per-game jogada bus width
//  SCORE_W          3     per-game score width
//  INTERVAL_CYCLES  2000  cycles spent in INTERVALO before start (>=1)
//  CNT_W            32    interval counter width
// PORTS
//  clock            in   1                  system (divided) clock, all logic on rising edge
//  reset            in   1                  synchronous, active-high
//  iniciar          in   1                  start/restart request (level, active-high)
//  abortar          in   1                  abandon current game (level, active-high)
//  dificuldade      in   1                  difficulty switch
//  minigame         in   SEL_W              game select switch
//  game_estado      in   NUM_GAMES*STATE_W  flattened; game i at [i*STATE_W +: STATE_W]
//  game_jogada      in   NUM_GAMES*JOG_W    flattened, same packing
//  game_pontuacao   in   NUM_GAMES*SCORE_W  flattened, same packing
//  game_pronto      in   NUM_GAMES          per-game done flag
//  jogar            out  1                  one-cycle start pulse to the selected core only
//  jogar_vec        out  NUM_GAMES          one-hot of jogar, bit sel_game
//  sel_game         out  SEL_W              latched select
//  sel_dificuldade  out  1                  latched difficulty
//  estado_out       out  STATE_W            display state (see BEHAVIOUR)
//  jogada_out       out  JOG_W              selected game jogada
//  pontuacao_out    out  SCORE_W            selected game live score
//  ultima_pontuacao out  SCORE_W            score captured at last completed game
//  seq_estado       out  3                  FSM state code
// BEHAVIOUR
//  - Reset: FSM=INICIAL; sel_game=NUM_GAMES-1; sel_dificuldade=0; counter=0.
//    jogar=0, jogar_vec=0, ultima_pontuacao=0, recorde=0. Reset wins over every event, in any state.
//  - State codes: INICIAL=0, PREPARACAO=1, EXECUCAO=2, FIM=3, INTERVALO=4, START=5.
//  - sel_game and sel_dificuldade are loaded from the inputs every cycle while in INICIAL or PREPARACAO.
//    They are frozen in all other states.
//  - Transitions:
//    INICIAL    -> PREPARACAO if iniciar.
//    PREPARACAO -> INTERVALO if sel_game < NUM_GAMES, else -> INICIAL (invalid/idle select).
//    INTERVALO  -> START after exactly INTERVAL_CYCLES cycles in INTERVALO.
//      Counter clears outside INTERVALO and flags done at INTERVAL_CYCLES-1.
//    START      -> EXECUCAO unconditionally. jogar=1 for exactly this cycle (registered output).
//    EXECUCAO   -> FIM if game_pronto[sel_game] or abortar.
//      If pronto is set, ultima_pontuacao <= selected score on that edge.
//      If abortar alone, no capture. Pronto and abortar together: pronto wins (capture).
//      game_pronto of unselected games is ignored.
//    FIM        -> PREPARACAO if iniciar. Iniciar held high restarts immediately.
//  - estado_out:
//    INICIAL/PREPARACAO: zero-extended seq_estado.
//    INTERVALO: 4'h1.
//    START/EXECUCAO/FIM: selected game estado.
//  - jogada_out and pontuacao_out: selected game buses in all states, combinational mux, 0 latency.
// CONFIGURATION
//  SEQ_HIGHSCORE_EN defined:
//  - Per-game recorde register array and output recorde_out [SCORE_W].
//  - recorde_out shows recorde[sel_game].
//  - On each capture: recorde[sel_game] <= max(old, new). Compare is unsigned.
//  - The array clears only on reset.
//  SEQ_HIGHSCORE_EN not defined: no array, and the recorde_out port is absent.
// TESTING
//  - Reset then idle: seq_estado=0, jogar=0, estado_out=0, ultima_pontuacao=0.
//  - minigame=1, iniciar pulse: PREPARACAO, then INTERVALO with estado_out=1 for 2000 cycles.
//    Then START with jogar=1 for 1 cycle and jogar_vec=4'b0010.
//  - In EXECUCAO, pontuacao of game 1 = 3'd5, pulse game_pronto[1]: FIM, ultima_pontuacao=5.
//    game_pronto[2] alone: no transition.
//  - minigame=3 with NUM_GAMES=3: PREPARACAO -> INICIAL, jogar never asserted.
//  - abortar in EXECUCAO: FIM, ultima_pontuacao unchanged. Pronto+abortar same cycle: score captured.
//  - Reset in INTERVALO at cycle 1000: INICIAL next edge, counter 0. Restart gives a full 2000-cycle interval.
//    With SEQ_HIGHSCORE_EN, scores 4 then 2 on game 0: recorde_out=4.

Source files
------------

// File: rtl/minigame_sequencer_if.sv
// minigame_sequencer_if: board/core bus bundle between the minigame sequencer and its surroundings.
// recorde_out exists only when SEQ_HIGHSCORE_EN is defined.
interface minigame_sequencer_if #(
    parameter int NUM_GAMES = 4,
    parameter int SEL_W     = 2,
    parameter int STATE_W   = 4,
    parameter int JOG_W     = 7,
    parameter int SCORE_W   = 3
);
    logic                         iniciar;
    logic                         abortar;
    logic                         dificuldade;
    logic [SEL_W-1:0]             minigame;
    logic [NUM_GAMES*STATE_W-1:0] game_estado;
    logic [NUM_GAMES*JOG_W-1:0]   game_jogada;
    logic [NUM_GAMES*SCORE_W-1:0] game_pontuacao;
    logic [NUM_GAMES-1:0]         game_pronto;
    logic                         jogar;
    logic [NUM_GAMES-1:0]         jogar_vec;
    logic [SEL_W-1:0]             sel_game;
    logic                         sel_dificuldade;
    logic [STATE_W-1:0]           estado_out;
    logic [JOG_W-1:0]             jogada_out;
    logic [SCORE_W-1:0]           pontuacao_out;
    logic [SCORE_W-1:0]           ultima_pontuacao;
    logic [2:0]                   seq_estado;
`ifdef SEQ_HIGHSCORE_EN
    logic [SCORE_W-1:0]           recorde_out;
`endif
    modport master (
        output iniciar, abortar, dificuldade, minigame, game_estado, game_jogada, game_pontuacao, game_pronto,
        input  jogar, jogar_vec, sel_game, sel_dificuldade, estado_out, jogada_out, pontuacao_out,
               ultima_pontuacao, seq_estado
`ifdef SEQ_HIGHSCORE_EN
               , recorde_out
`endif
    );
    modport slave (
        input  iniciar, abortar, dificuldade, minigame, game_estado, game_jogada, game_pontuacao, game_pronto,
        output jogar, jogar_vec, sel_game, sel_dificuldade, estado_out, jogada_out, pontuacao_out,
               ultima_pontuacao, seq_estado
`ifdef SEQ_HIGHSCORE_EN
               , recorde_out
`endif
    );
endinterface

// File: rtl/minigame_sequencer.sv
// minigame_sequencer: session FSM, select latch and per-game bus mux for NUM_GAMES minigame cores.
// Define SEQ_HIGHSCORE_EN to add the per-game high-score array and recorde_out.
module minigame_sequencer #(
    parameter int NUM_GAMES       = 4,
    parameter int SEL_W           = 2,
    parameter int STATE_W         = 4,
    parameter int JOG_W           = 7,
    parameter int SCORE_W         = 3,
    parameter int INTERVAL_CYCLES = 2000,
    parameter int CNT_W           = 32
) (
    input logic clock,
    input logic reset,
    minigame_sequencer_if.slave bus
);
    localparam logic [2:0] INICIAL    = 3'd0;
    localparam logic [2:0] PREPARACAO = 3'd1;
    localparam logic [2:0] EXECUCAO   = 3'd2;
    localparam logic [2:0] FIM        = 3'd3;
    localparam logic [2:0] INTERVALO  = 3'd4;
    localparam logic [2:0] START      = 3'd5;
    logic [2:0]           state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 dif_q, dif_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 jogar_q, jogar_d;
    logic [NUM_GAMES-1:0] jvec_q, jvec_d;
    logic [SCORE_W-1:0]   ult_q, ult_d;
    logic                 sel_ok, in_ok, loading, pronto, cnt_done, capture;
    logic [STATE_W-1:0]   g_estado;
    logic [JOG_W-1:0]     g_jog;
    logic [SCORE_W-1:0]   g_pont;
    // Out-of-range selects read as zero instead of indexing past the flattened buses.
    assign sel_ok   = 32'(sel_q) < NUM_GAMES;
    assign in_ok    = 32'(bus.minigame) < NUM_GAMES;
    assign g_estado = sel_ok ? bus.game_estado[sel_q*STATE_W +: STATE_W] : '0;
    assign g_jog    = sel_ok ? bus.game_jogada[sel_q*JOG_W +: JOG_W] : '0;
    assign g_pont   = sel_ok ? bus.game_pontuacao[sel_q*SCORE_W +: SCORE_W] : '0;
    assign pronto   = sel_ok & bus.game_pronto[sel_q];
    assign cnt_done = cnt_q == CNT_W'(INTERVAL_CYCLES - 1);
    assign loading  = state_q == INICIAL || state_q == PREPARACAO;
    assign capture  = state_q == EXECUCAO && pronto;
    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:    state_d = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: state_d = in_ok ? INTERVALO : INICIAL;
            INTERVALO:  state_d = cnt_done ? START : INTERVALO;
            START:      state_d = EXECUCAO;
            EXECUCAO:   state_d = (pronto || bus.abortar) ? FIM : EXECUCAO;
            FIM:        state_d = bus.iniciar ? PREPARACAO : FIM;
            default:    state_d = INICIAL;
        endcase
        sel_d   = loading ? bus.minigame : sel_q;
        dif_d   = loading ? bus.dificuldade : dif_q;
        cnt_d   = (state_q == INTERVALO && !cnt_done) ? cnt_q + 1'b1 : '0;
        jogar_d = state_d == START;
        jvec_d  = jogar_d ? NUM_GAMES'(1) << sel_q : '0;
        ult_d   = capture ? g_pont : ult_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INICIAL;
            sel_q   <= SEL_W'(NUM_GAMES - 1);
            dif_q   <= 1'b0;
            cnt_q   <= '0;
            jogar_q <= 1'b0;
            jvec_q  <= '0;
            ult_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dif_q   <= dif_d;
            cnt_q   <= cnt_d;
            jogar_q <= jogar_d;
            jvec_q  <= jvec_d;
            ult_q   <= ult_d;
        end
    end
    assign bus.jogar            = jogar_q;
    assign bus.jogar_vec        = jvec_q;
    assign bus.sel_game         = sel_q;
    assign bus.sel_dificuldade  = dif_q;
    assign bus.seq_estado       = state_q;
    assign bus.jogada_out       = g_jog;
    assign bus.pontuacao_out    = g_pont;
    assign bus.ultima_pontuacao = ult_q;
    assign bus.estado_out       = loading ? STATE_W'(state_q) : state_q == INTERVALO ? STATE_W'(1) : g_estado;
`ifdef SEQ_HIGHSCORE_EN
    logic [SCORE_W-1:0] rec_q [NUM_GAMES];
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_GAMES; i++) rec_q[i] <= '0;
        end else if (capture && g_pont > rec_q[sel_q]) begin
            rec_q[sel_q] <= g_pont;
        end
    end
    assign bus.recorde_out = sel_ok ? rec_q[sel_q] : '0;
`else
`endif
endmodule

// File: tb/tb_minigame_sequencer.sv
// tb_minigame_sequencer: directed/table checks on a 4-game build, randomized model check on a 3-game build.
module tb_minigame_sequencer;
    logic clk = 1'b0;
    logic rst;
    int n_pass = 0;
    int n_tot = 0;
    always #5 clk = ~clk;

    minigame_sequencer_if #(.NUM_GAMES(4)) a ();
    minigame_sequencer_if #(.NUM_GAMES(3)) b ();
    minigame_sequencer #(.NUM_GAMES(4)) dut_a (.clock(clk), .reset(rst), .bus(a.slave));
    minigame_sequencer #(.NUM_GAMES(3), .INTERVAL_CYCLES(3)) dut_b (.clock(clk), .reset(rst), .bus(b.slave));

    typedef struct {
        logic [1:0] mg;
        logic       dif;
        logic [1:0] sel;
        logic       sdif;
        logic [6:0] jog;
        logic [2:0] pont;
    } vec_t;
    vec_t tbl [4];

    logic [3:0] es [3];
    logic [6:0] jg [3];
    logic [2:0] pt [3];
    logic [2:0] pr;
    int m_st, m_sel, m_dif, m_t, m_ult, ns;
    int m_rec [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_interval(output int n);
        n = 0;
        while (a.seq_estado == 3'd4 && n < 2100) begin
            n++;
            step();
        end
    endtask

    task automatic to_exec();
        int n;
        a.iniciar = 1'b1;
        step();
        a.iniciar = 1'b0;
        step();
        wait_interval(n);
        chk("interval_len", n, 2000);
        step();
        chk("in_exec", a.seq_estado, 2);
    endtask

    initial begin
        int n, bad;
        rst = 1'b1;
        a.iniciar = 0; a.abortar = 0; a.dificuldade = 0; a.minigame = 0; a.game_pronto = 0;
        a.game_estado    = {4'hd, 4'hc, 4'hb, 4'ha};
        a.game_jogada    = {7'd40, 7'd30, 7'd20, 7'd10};
        a.game_pontuacao = {3'd7, 3'd6, 3'd5, 3'd4};
        b.iniciar = 0; b.abortar = 0; b.dificuldade = 0; b.minigame = 0; b.game_pronto = 0;
        b.game_estado = 0; b.game_jogada = 0; b.game_pontuacao = 0;
        step();
        step();
        chk("rst_seq", a.seq_estado, 0);
        chk("rst_jogar", a.jogar, 0);
        chk("rst_jvec", a.jogar_vec, 0);
        chk("rst_estado", a.estado_out, 0);
        chk("rst_ultima", a.ultima_pontuacao, 0);
        chk("rst_sel", a.sel_game, 3);
        chk("rst_dif", a.sel_dificuldade, 0);
        rst = 1'b0;

        tbl[0] = '{2'd0, 1'b0, 2'd0, 1'b0, 7'd10, 3'd4};
        tbl[1] = '{2'd1, 1'b1, 2'd1, 1'b1, 7'd20, 3'd5};
        tbl[2] = '{2'd2, 1'b0, 2'd2, 1'b0, 7'd30, 3'd6};
        tbl[3] = '{2'd3, 1'b1, 2'd3, 1'b1, 7'd40, 3'd7};
        for (int i = 0; i < 4; i++) begin
            a.minigame = tbl[i].mg;
            a.dificuldade = tbl[i].dif;
            step();
            chk("tbl_sel", a.sel_game, tbl[i].sel);
            chk("tbl_dif", a.sel_dificuldade, tbl[i].sdif);
            chk("tbl_jog", a.jogada_out, tbl[i].jog);
            chk("tbl_pont", a.pontuacao_out, tbl[i].pont);
            chk("tbl_seq", a.seq_estado, 0);
            chk("tbl_estado", a.estado_out, 0);
        end

        a.minigame = 1; a.dificuldade = 0; a.iniciar = 1;
        step();
        chk("prep_seq", a.seq_estado, 1);
        chk("prep_estado", a.estado_out, 1);
        a.iniciar = 0;
        step();
        chk("int_seq", a.seq_estado, 4);
        n = 0; bad = 0;
        while (a.seq_estado == 3'd4 && n < 2100) begin
            if (a.estado_out != 4'h1) bad++;
            n++;
            step();
        end
        chk("int_len", n, 2000);
        chk("int_estado_bad", bad, 0);
        chk("start_seq", a.seq_estado, 5);
        chk("start_jogar", a.jogar, 1);
        chk("start_jvec", a.jogar_vec, 4'b0010);
        chk("start_estado", a.estado_out, 4'hb);
        step();
        chk("exec_seq", a.seq_estado, 2);
        chk("exec_jogar", a.jogar, 0);
        chk("exec_jvec", a.jogar_vec, 0);
        a.game_pronto = 4'b0100;
        step();
        chk("other_pronto_seq", a.seq_estado, 2);
        chk("other_pronto_ult", a.ultima_pontuacao, 0);
        a.game_pronto = 4'b0010;
        step();
        a.game_pronto = 0;
        chk("done_seq", a.seq_estado, 3);
        chk("done_ult", a.ultima_pontuacao, 5);
        chk("fim_estado", a.estado_out, 4'hb);

        a.iniciar = 1;
        step();
        chk("restart_prep", a.seq_estado, 1);
        step();
        chk("restart_int", a.seq_estado, 4);
        a.iniciar = 0;
        wait_interval(n);
        chk("restart_len", n, 2000);
        step();
        a.abortar = 1;
        step();
        a.abortar = 0;
        chk("abort_seq", a.seq_estado, 3);
        chk("abort_ult", a.ultima_pontuacao, 5);

        a.game_pontuacao = {3'd7, 3'd6, 3'd3, 3'd4};
        to_exec();
        a.game_pronto = 4'b0010; a.abortar = 1;
        step();
        a.game_pronto = 0; a.abortar = 0;
        chk("both_seq", a.seq_estado, 3);
        chk("both_ult", a.ultima_pontuacao, 3);

        a.iniciar = 1;
        step();
        a.iniciar = 0;
        step();
        repeat (999) step();
        chk("mid_int_seq", a.seq_estado, 4);
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_seq", a.seq_estado, 0);
        chk("mid_rst_ult", a.ultima_pontuacao, 0);
        to_exec();

        a.minigame = 0;
        a.game_pronto = 4'b0010;
        step();
        a.game_pronto = 0;
        to_exec();
        a.game_pronto = 4'b0001;
        step();
        a.game_pronto = 0;
        chk("g0_ult4", a.ultima_pontuacao, 4);
`ifdef SEQ_HIGHSCORE_EN
        chk("g0_rec4", a.recorde_out, 4);
`endif
        a.game_pontuacao = {3'd7, 3'd6, 3'd3, 3'd2};
        to_exec();
        a.game_pronto = 4'b0001;
        step();
        a.game_pronto = 0;
        chk("g0_ult2", a.ultima_pontuacao, 2);
`ifdef SEQ_HIGHSCORE_EN
        chk("g0_rec_keep", a.recorde_out, 4);
`endif

        rst = 1;
        step();
        rst = 0;
        m_st = 0; m_sel = 2; m_dif = 0; m_t = 0; m_ult = 0;
        for (int i = 0; i < 3; i++) m_rec[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            b.iniciar = ($urandom % 4) == 0;
            b.abortar = ($urandom % 8) == 0;
            b.dificuldade = 1'($urandom);
            b.minigame = 2'($urandom);
            for (int i = 0; i < 3; i++) begin
                es[i] = 4'($urandom);
                jg[i] = 7'($urandom);
                pt[i] = 3'($urandom);
                pr[i] = ($urandom % 4) == 0;
            end
            b.game_estado = {es[2], es[1], es[0]};
            b.game_jogada = {jg[2], jg[1], jg[0]};
            b.game_pontuacao = {pt[2], pt[1], pt[0]};
            b.game_pronto = pr;
            rst = ($urandom % 97) == 0;
            #1;
            chk("r_seq", b.seq_estado, m_st);
            chk("r_jogar", b.jogar, m_st == 5);
            chk("r_jvec", b.jogar_vec, m_st == 5 ? (1 << m_sel) : 0);
            chk("r_sel", b.sel_game, m_sel);
            chk("r_dif", b.sel_dificuldade, m_dif);
            chk("r_estado", b.estado_out, m_st <= 1 ? m_st : m_st == 4 ? 1 : es[m_sel]);
            chk("r_ult", b.ultima_pontuacao, m_ult);
            if (m_sel < 3) begin
                chk("r_jog", b.jogada_out, jg[m_sel]);
                chk("r_pont", b.pontuacao_out, pt[m_sel]);
`ifdef SEQ_HIGHSCORE_EN
                chk("r_rec", b.recorde_out, m_rec[m_sel]);
`endif
            end
            @(posedge clk);
            if (rst) begin
                m_st = 0; m_sel = 2; m_dif = 0; m_t = 0; m_ult = 0;
                for (int i = 0; i < 3; i++) m_rec[i] = 0;
            end else begin
                ns = m_st;
                case (m_st)
                    0: if (b.iniciar) ns = 1;
                    1: ns = (b.minigame < 3) ? 4 : 0;
                    4: begin
                        m_t++;
                        if (m_t == 3) begin
                            ns = 5;
                            m_t = 0;
                        end
                    end
                    5: ns = 2;
                    2: if (pr[m_sel]) begin
                        ns = 3;
                        m_ult = pt[m_sel];
                        if (pt[m_sel] > m_rec[m_sel]) m_rec[m_sel] = pt[m_sel];
                    end else if (b.abortar) ns = 3;
                    3: if (b.iniciar) ns = 1;
                    default: ns = 0;
                endcase
                if (m_st <= 1) begin
                    m_sel = b.minigame;
                    m_dif = b.dificuldade;
                end
                m_st = ns;
            end
            #1;
        end
        rst = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
